jtag_ir_driver: RTL and testbench

JTAG_IR_DRIVER -- requirements
Module: jtag_ir_driver

---
 rtl/jtag_ir_driver.sv | 123 ++++++++++++
 tb/tb_jtag_ir_driver.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_ir_driver.sv
// JTAG IR loader: walks the TAP to Run-Test/Idle after reset, then shifts each requested
// instruction into the IR (LSB first) while collecting the capture value from tdo.
module jtag_ir_driver #(
   parameter int unsigned INSTR_WIDTH = 4,
   parameter int unsigned TCK_DIV     = 2
) (
   input  logic                   clock,
   input  logic                   reset_n,
   input  logic                   start,
   input  logic [INSTR_WIDTH-1:0] instr_i,
   input  logic                   tdo,
   output logic                   tck,
   output logic                   tms,
   output logic                   tdi,
   output logic                   busy,
   output logic                   done,
   output logic [INSTR_WIDTH-1:0] captured_o
);

   localparam int unsigned NumSlots   = INSTR_WIDTH + 6;
   localparam int unsigned SlotClks   = 2 * TCK_DIV;
   localparam int unsigned SlotW      = $clog2(NumSlots);
   localparam int unsigned DivW       = $clog2(SlotClks);
   localparam int unsigned InitSlots  = 6;
   localparam int unsigned FirstShift = 4;

   typedef enum logic [1:0] {StInit, StReady, StShift} state_e;

   state_e                 state_q, state_d;
   logic [DivW-1:0]        div_q, div_d;
   logic [SlotW-1:0]       slot_q, slot_d;
   logic [INSTR_WIDTH-1:0] instr_q, instr_d;
   logic [INSTR_WIDTH-1:0] cap_q, cap_d;
   logic [INSTR_WIDTH-1:0] captured_q, captured_d;
   logic                   done_q, done_d;

   logic slot_end;
   logic in_shift;

   assign slot_end = (div_q == DivW'(SlotClks - 1));
   assign in_shift = (state_q == StShift) && (slot_q >= SlotW'(FirstShift)) &&
                     (slot_q < SlotW'(FirstShift + INSTR_WIDTH));

   assign busy       = (state_q != StReady);
   assign tck        = busy && (div_q >= DivW'(TCK_DIV));
   assign done       = done_q;
   assign captured_o = captured_q;
   // instr_q is consumed by shifting right, so bit 0 is always the current shift bit
   assign tdi        = in_shift ? instr_q[0] : 1'b0;

   always_comb begin
      tms = 1'b0;
      case (state_q)
         StInit:  tms = (slot_q != SlotW'(InitSlots - 1));
         // Select-DR, Select-IR, then Exit1-IR on the last shift slot and Update-IR
         StShift: tms = (slot_q < SlotW'(2)) || (slot_q == SlotW'(INSTR_WIDTH + 3)) ||
                        (slot_q == SlotW'(INSTR_WIDTH + 4));
         default: tms = 1'b0;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      div_d      = div_q;
      slot_d     = slot_q;
      instr_d    = instr_q;
      cap_d      = cap_q;
      captured_d = captured_q;
      done_d     = 1'b0;
      case (state_q)
         StReady: begin
            // a start coinciding with done is dropped on purpose
            if (start && !done_q) begin
               instr_d = instr_i;
               state_d = StShift;
            end
         end
         default: begin
            if (slot_end) begin
               div_d  = '0;
               slot_d = slot_q + 1'b1;
               if (in_shift) begin
                  cap_d   = {tdo, cap_q[INSTR_WIDTH-1:1]};
                  instr_d = instr_q >> 1;
               end
               if (state_q == StInit && slot_q == SlotW'(InitSlots - 1)) begin
                  state_d = StReady;
                  slot_d  = '0;
               end
               if (state_q == StShift && slot_q == SlotW'(NumSlots - 1)) begin
                  state_d    = StReady;
                  slot_d     = '0;
                  done_d     = 1'b1;
                  captured_d = cap_q;
               end
            end else begin
               div_d = div_q + 1'b1;
            end
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= StInit;
         div_q      <= '0;
         slot_q     <= '0;
         instr_q    <= '0;
         cap_q      <= '0;
         captured_q <= '0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         div_q      <= div_d;
         slot_q     <= slot_d;
         instr_q    <= instr_d;
         cap_q      <= cap_d;
         captured_q <= captured_d;
         done_q     <= done_d;
      end
   end

endmodule

// File: tb/tb_jtag_ir_driver.sv
// Bench for jtag_ir_driver: a behavioural TAP model answers on tdo, a vector table drives
// IR loads and a scoreboard checks capture and loaded IR when done pulses.
module tb_jtag_ir_driver;

   localparam int W = 4;
   localparam int D = 2;

   logic         clock   = 1'b0;
   logic         reset_n = 1'b0;
   logic         start   = 1'b0;
   logic [W-1:0] instr_i = '0;
   logic         tdo     = 1'b0;
   logic         tck, tms, tdi, busy, done;
   logic [W-1:0] captured_o;

   logic         start8 = 1'b0;
   logic [7:0]   instr8 = '0;
   logic         tdo8   = 1'b1;
   logic         tck8, tms8, tdi8, busy8, done8;
   logic [7:0]   captured8;

   always #5 clock = ~clock;

   jtag_ir_driver #(.INSTR_WIDTH(W), .TCK_DIV(D)) dut (
      .clock(clock), .reset_n(reset_n), .start(start), .instr_i(instr_i), .tdo(tdo),
      .tck(tck), .tms(tms), .tdi(tdi), .busy(busy), .done(done), .captured_o(captured_o)
   );

   jtag_ir_driver #(.INSTR_WIDTH(8), .TCK_DIV(1)) dut8 (
      .clock(clock), .reset_n(reset_n), .start(start8), .instr_i(instr8), .tdo(tdo8),
      .tck(tck8), .tms(tms8), .tdi(tdi8), .busy(busy8), .done(done8), .captured_o(captured8)
   );

   int n_err = 0;
   int n_chk = 0;
   int done_cnt = 0;
   logic [W-1:0] last_cap = '0;

   always @(posedge clock) if (done) done_cnt <= done_cnt + 1;

   bit     tms_log[$];
   bit     tdi_log[$];
   longint rise_t[$];
   bit     tms8_log[$];
   bit     tdi8_log[$];
   longint rise8_t[$];

   always @(posedge tck) begin
      tms_log.push_back(tms);
      tdi_log.push_back(tdi);
      rise_t.push_back(longint'($time));
   end

   always @(posedge tck8) begin
      tms8_log.push_back(tms8);
      tdi8_log.push_back(tdi8);
      rise8_t.push_back(longint'($time));
   end

   // Behavioural IEEE 1149.1 TAP with a W-bit IR
   typedef enum logic [3:0] {
      TapReset, TapIdle, SelDr, CapDr, ShDr, Ex1Dr, PauDr, Ex2Dr, UpdDr,
      SelIr, CapIr, ShIr, Ex1Ir, PauIr, Ex2Ir, UpdIr
   } tap_e;

   tap_e         tap_st  = TapReset;
   logic [W-1:0] tap_sr  = '0;
   logic [W-1:0] tap_ir  = '0;
   logic [W-1:0] cap_val = '0;

   function automatic tap_e tap_next(input tap_e s, input logic m);
      case (s)
         TapReset: return m ? TapReset : TapIdle;
         TapIdle:  return m ? SelDr : TapIdle;
         SelDr:    return m ? SelIr : CapDr;
         CapDr:    return m ? Ex1Dr : ShDr;
         ShDr:     return m ? Ex1Dr : ShDr;
         Ex1Dr:    return m ? UpdDr : PauDr;
         PauDr:    return m ? Ex2Dr : PauDr;
         Ex2Dr:    return m ? UpdDr : ShDr;
         UpdDr:    return m ? SelDr : TapIdle;
         SelIr:    return m ? TapReset : CapIr;
         CapIr:    return m ? Ex1Ir : ShIr;
         ShIr:     return m ? Ex1Ir : ShIr;
         Ex1Ir:    return m ? UpdIr : PauIr;
         PauIr:    return m ? Ex2Ir : PauIr;
         Ex2Ir:    return m ? UpdIr : ShIr;
         default:  return m ? SelDr : TapIdle;
      endcase
   endfunction

   always @(posedge tck) begin
      if (tap_st == CapIr) tap_sr <= cap_val;
      else if (tap_st == ShIr) tap_sr <= {tdi, tap_sr[W-1:1]};
      tap_st <= tap_next(tap_st, tms);
   end

   always @(negedge tck) begin
      tdo <= (tap_st == ShIr) ? tap_sr[0] : 1'b0;
      if (tap_st == UpdIr) tap_ir <= tap_sr;
   end

   typedef struct {
      logic [W-1:0] instr;
      logic [W-1:0] cap;
      int           extra;
      logic [W-1:0] exp_captured;
   } vec_t;

   typedef struct {
      logic [W-1:0] captured;
      logic [W-1:0] ir;
   } exp_t;

   exp_t sb[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] pack(input bit q[$]);
      logic [31:0] v;
      v = '0;
      for (int i = 0; i < q.size() && i < 32; i++) v[i] = q[i];
      return v;
   endfunction

   // Common tck period in clocks, or -1 if rises are irregular or too few
   function automatic int period(input longint q[$]);
      int p;
      if (q.size() < 2) return -1;
      p = int'((q[1] - q[0]) / 10);
      for (int i = 2; i < q.size(); i++) if (int'((q[i] - q[i-1]) / 10) != p) return -1;
      return p;
   endfunction

   task automatic check_reset_vals(input string name);
      check({name, "_tck"}, tck, 0);
      check({name, "_tms"}, tms, 1);
      check({name, "_tdi"}, tdi, 0);
      check({name, "_busy"}, busy, 1);
      check({name, "_done"}, done, 0);
      check({name, "_captured"}, captured_o, 0);
   endtask

   task automatic init_seq(input bit with_start);
      int fell;
      int base;
      fell = 0;
      @(negedge clock);
      base = done_cnt;
      tms_log.delete(); tdi_log.delete(); rise_t.delete();
      reset_n = 1'b1;
      for (int k = 1; k <= 40; k++) begin
         if (k > 1) @(negedge clock);
         start = with_start && (k >= 5) && (k <= 10);
         if (!busy && fell == 0) fell = k;
      end
      start = 1'b0;
      check("init_busy_fall", fell, 25);
      check("init_slots", tms_log.size(), 6);
      check("init_tms", pack(tms_log), 32'b011111);
      check("init_tdi", pack(tdi_log), 0);
      check("init_tck_period", period(rise_t), 2 * D);
      check("init_tap_idle", tap_st == TapIdle, 1);
      check("init_captured", captured_o, 0);
      check("init_no_done", done_cnt - base, 0);
   endtask

   task automatic run_vec(input logic [W-1:0] ins, input logic [W-1:0] cap, input int extra,
                          input logic [W-1:0] exp_cap);
      exp_t e;
      int   lat;
      bit   got;
      int   base;
      @(negedge clock);
      tms_log.delete(); tdi_log.delete(); rise_t.delete();
      base    = done_cnt;
      cap_val = cap;
      instr_i = ins;
      start   = 1'b1;
      sb.push_back('{exp_cap, ins});
      lat = 0;
      got = 1'b0;
      while (!got && lat < 200) begin
         @(negedge clock);
         lat++;
         start   = (lat == extra);
         instr_i = W'($urandom);
         if (lat == 20) check("captured_hold", captured_o, last_cap);
         if (done) begin
            got   = 1'b1;
            start = 1'b1;
         end
      end
      check("done_latency", lat, 41);
      check("busy_at_done", busy, 0);
      check("tck_idle_at_done", tck, 0);
      check("sb_entry", sb.size() > 0, 1);
      if (sb.size() > 0) begin
         e = sb.pop_front();
         check("captured", captured_o, e.captured);
         check("tap_ir", tap_ir, e.ir);
         last_cap = e.captured;
      end
      @(negedge clock);
      start = 1'b0;
      check("done_one_cycle", done, 0);
      check("start_at_done_ignored", busy, 0);
      repeat (3) @(negedge clock);
      check("done_count", done_cnt - base, 1);
      check("shift_slots", tms_log.size(), 10);
      check("shift_tms", pack(tms_log), 32'b0110000011);
      check("shift_tdi", pack(tdi_log), {22'b0, 2'b00, ins, 4'b0000});
      check("shift_tck_period", period(rise_t), 2 * D);
   endtask

   task automatic run8();
      int lat;
      bit got;
      @(negedge clock);
      tms8_log.delete(); tdi8_log.delete(); rise8_t.delete();
      instr8 = 8'hA5;
      start8 = 1'b1;
      lat = 0;
      got = 1'b0;
      while (!got && lat < 200) begin
         @(negedge clock);
         lat++;
         start8 = 1'b0;
         if (done8) got = 1'b1;
      end
      check("w8_latency", lat, 29);
      check("w8_busy_at_done", busy8, 0);
      check("w8_slots", tms8_log.size(), 14);
      check("w8_tck_period", period(rise8_t), 2);
      check("w8_tms", pack(tms8_log), 32'b01100000000011);
      check("w8_tdi", pack(tdi8_log), {18'b0, 2'b00, 8'hA5, 4'h0});
      check("w8_captured", captured8, 8'hFF);
   endtask

   initial begin
      vec_t vecs[4];
      vecs[0] = '{4'b1010, 4'b0001, 0,  4'b0001};
      vecs[1] = '{4'b0110, 4'b1001, 14, 4'b1001};
      vecs[2] = '{4'b1111, 4'b0000, 3,  4'b0000};
      vecs[3] = '{4'b0000, 4'b1110, 40, 4'b1110};

      repeat (3) @(negedge clock);
      check_reset_vals("reset");
      init_seq(1'b1);

      for (int i = 0; i < 4; i++) run_vec(vecs[i].instr, vecs[i].cap, vecs[i].extra,
                                          vecs[i].exp_captured);

      // Abort a load in its third slot with reset
      @(negedge clock);
      instr_i = 4'b0011;
      cap_val = 4'b1111;
      start   = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clock);
         start = 1'b0;
      end
      reset_n = 1'b0;
      #1;
      check_reset_vals("mid_reset");
      last_cap = '0;
      repeat (3) @(negedge clock);
      init_seq(1'b0);
      run_vec(4'b0110, 4'b0101, 0, 4'b0101);

      run8();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
